uart_tx_frame: RTL and testbench

Parametrised UART transmitter that serialises one data word per frame: start bit, data LSB-first, optional parity, then one or two stop bits. Each bit lasts a run-time-programmable number of clocks, so the block sits directly on the system clock with no external baud-tick generator. It is the drop-in successor to the fixed 8-bit, one-clock-per-bit transmitter, driven by the same register/FIFO front end, and adds width, baud and stop-bit generality.

---
 rtl/uart_tx_frame.sv | 198 +++++++++++++++++++
 tb/tb_uart_tx_frame.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmitter, one word per frame.
// Frame = start bit, DATA_WIDTH data bits LSB first, optional parity,
// one or two stop bits. Each bit lasts PRESCALE+1 clocks.
// Optional feature macro: UART_TX_HOLD_EN adds a one-word holding register
// so a word offered during a frame is sent back-to-back after it.
//
// Handshake: a word is accepted on a rising edge where DATA_VALID=1 and
// READY=1. READY may be low; DATA_VALID while READY=0 is dropped and not
// remembered. P_DATA and the config inputs are only sampled at accept.
`timescale 1ns/1ps
module uart_tx_frame #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [DATA_WIDTH-1:0]     P_DATA,
  input  logic                      DATA_VALID,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic                      STOP2,
  input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
  output logic                      TX_OUT,
  output logic                      BUSY,
  output logic                      READY,
  output logic [2:0]                DBG_STATE
);

  localparam int                IDX_W    = $clog2(DATA_WIDTH);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP1  = 3'd4,
    S_STOP2  = 3'd5
  } state_t;

  state_t                    state_q;
  logic [PRESCALE_WIDTH-1:0] cnt_q;
  logic [PRESCALE_WIDTH-1:0] pre_q;
  logic [IDX_W-1:0]          bit_idx_q;
  logic [DATA_WIDTH-1:0]     shreg_q;
  logic                      par_bit_q;
  logic                      par_en_q;
  logic                      stop2_q;
  logic                      tx_q;
  logic                      busy_q;

  logic                      bit_end;
  logic                      frame_end;
  logic                      slot_free;
  logic                      accept;
  logic                      load_go;
  logic [DATA_WIDTH-1:0]     load_data;
  logic                      load_par_en;
  logic                      load_par_typ;
  logic                      load_stop2;
  logic [PRESCALE_WIDTH-1:0] load_pre;
  logic                      load_par_bit;

  // Bit timing and "shifter may take a new word" decode.
  always_comb begin
    bit_end   = (cnt_q == pre_q);
    frame_end = bit_end && (((state_q == S_STOP1) && !stop2_q) ||
                            (state_q == S_STOP2));
    slot_free = (state_q == S_IDLE) || frame_end;
  end

`ifdef UART_TX_HOLD_EN
  logic                      hold_valid_q;
  logic [DATA_WIDTH-1:0]     hold_data_q;
  logic                      hold_par_en_q;
  logic                      hold_par_typ_q;
  logic                      hold_stop2_q;
  logic [PRESCALE_WIDTH-1:0] hold_pre_q;
  logic                      hold_fill;

  // Source selection: a held word always goes before a fresh one.
  always_comb begin
    READY        = !hold_valid_q;
    accept       = DATA_VALID && READY;
    load_go      = slot_free && (hold_valid_q || accept);
    hold_fill    = accept && !slot_free;
    load_data    = hold_valid_q ? hold_data_q    : P_DATA;
    load_par_en  = hold_valid_q ? hold_par_en_q  : PAR_EN;
    load_par_typ = hold_valid_q ? hold_par_typ_q : PAR_TYP;
    load_stop2   = hold_valid_q ? hold_stop2_q   : STOP2;
    load_pre     = hold_valid_q ? hold_pre_q     : PRESCALE;
    load_par_bit = (^load_data) ^ load_par_typ;
  end

  // Holding register: filled by an accept mid-frame, drained at frame end.
  always_ff @(posedge CLK) begin
    if (RST) begin
      hold_valid_q <= 1'b0;
    end else if (hold_fill) begin
      hold_valid_q   <= 1'b1;
      hold_data_q    <= P_DATA;
      hold_par_en_q  <= PAR_EN;
      hold_par_typ_q <= PAR_TYP;
      hold_stop2_q   <= STOP2;
      hold_pre_q     <= PRESCALE;
    end else if (slot_free && hold_valid_q) begin
      hold_valid_q <= 1'b0;
    end
  end
`else
  // Without a hold register the shifter takes the word directly.
  always_comb begin
    READY        = slot_free;
    accept       = DATA_VALID && READY;
    load_go      = accept;
    load_data    = P_DATA;
    load_par_en  = PAR_EN;
    load_par_typ = PAR_TYP;
    load_stop2   = STOP2;
    load_pre     = PRESCALE;
    load_par_bit = (^load_data) ^ load_par_typ;
  end
`endif

  // Frame FSM; TX_OUT and BUSY are registered from the next state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      pre_q     <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      par_bit_q <= 1'b0;
      par_en_q  <= 1'b0;
      stop2_q   <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else if (slot_free) begin
      if (load_go) begin
        state_q   <= S_START;
        cnt_q     <= '0;
        pre_q     <= load_pre;
        bit_idx_q <= '0;
        shreg_q   <= load_data;
        par_bit_q <= load_par_bit;
        par_en_q  <= load_par_en;
        stop2_q   <= load_stop2;
        tx_q      <= 1'b0;
        busy_q    <= 1'b1;
      end else if (frame_end) begin
        state_q <= S_IDLE;
        cnt_q   <= '0;
        tx_q    <= 1'b1;
        busy_q  <= 1'b0;
      end
    end else if (bit_end) begin
      cnt_q <= '0;
      case (state_q)
        S_START: begin
          state_q   <= S_DATA;
          bit_idx_q <= '0;
          tx_q      <= shreg_q[0];
        end
        S_DATA: begin
          if (bit_idx_q == LAST_IDX) begin
            state_q <= par_en_q ? S_PARITY : S_STOP1;
            tx_q    <= par_en_q ? par_bit_q : 1'b1;
          end else begin
            shreg_q   <= shreg_q >> 1;
            bit_idx_q <= bit_idx_q + IDX_W'(1);
            tx_q      <= shreg_q[1];
          end
        end
        S_PARITY: begin
          state_q <= S_STOP1;
          tx_q    <= 1'b1;
        end
        S_STOP1: begin
          // Only reached with two stop bits; one-stop end is frame_end.
          state_q <= S_STOP2;
          tx_q    <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end else begin
      cnt_q <= cnt_q + PRESCALE_WIDTH'(1);
    end
  end

  assign TX_OUT    = tx_q;
  assign BUSY      = busy_q;
  assign DBG_STATE = state_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: directed bench for uart_tx_frame (8-bit and 5-bit
// instances). Expected line sequences are hand-written bit strings, written
// in transmission order (leftmost bit goes on the line first).
`timescale 1ns/1ps
module tb_uart_tx_frame;

  // ---------------- clock / reset / signals ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] p_data;
  logic       data_valid;
  logic       par_en;
  logic       par_typ;
  logic       stop2;
  logic [7:0] prescale;
  logic       tx_out;
  logic       busy;
  logic       ready;
  logic [2:0] dbg_state;

  logic [4:0] p_data5;
  logic       data_valid5;
  logic       tx5;
  logic       busy5;
  logic       ready5;
  logic [2:0] dbg5;

  // Scoreboard entries are {BUSY, TX_OUT} per clock.
  logic [1:0] exp_q[$];
  int         checks   = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  uart_tx_frame #(.DATA_WIDTH(8), .PRESCALE_WIDTH(8)) u_dut (
    .CLK(clk), .RST(rst), .P_DATA(p_data), .DATA_VALID(data_valid),
    .PAR_EN(par_en), .PAR_TYP(par_typ), .STOP2(stop2), .PRESCALE(prescale),
    .TX_OUT(tx_out), .BUSY(busy), .READY(ready), .DBG_STATE(dbg_state)
  );

  uart_tx_frame #(.DATA_WIDTH(5), .PRESCALE_WIDTH(8)) u_dut5 (
    .CLK(clk), .RST(rst), .P_DATA(p_data5), .DATA_VALID(data_valid5),
    .PAR_EN(par_en), .PAR_TYP(par_typ), .STOP2(stop2), .PRESCALE(prescale),
    .TX_OUT(tx5), .BUSY(busy5), .READY(ready5), .DBG_STATE(dbg5)
  );

  // ---------------- driver / checker tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_bits(input logic [15:0] bits, input int n, input int rep,
                           input logic b);
    for (int i = n - 1; i >= 0; i--) begin
      repeat (rep) exp_q.push_back({b, bits[i]});
    end
  endtask

  task automatic push_idle(input int n);
    repeat (n) exp_q.push_back(2'b01);
  endtask

  // Compare n clocks of {BUSY,TX_OUT} against the scoreboard, then advance.
  task automatic run_check(input string tag, input bit sel, input int n);
    logic [1:0] e;
    logic [1:0] o;
    for (int i = 0; i < n; i++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 2'bxx;
      o = sel ? {busy5, tx5} : {busy, tx_out};
      chk($sformatf("%s[%0d]", tag, i), {6'b0, o}, {6'b0, e});
      tick();
    end
  endtask

  task automatic send(input logic [7:0] d, input logic pe, input logic pt,
                      input logic s2, input logic [7:0] pre);
    p_data     = d;
    par_en     = pe;
    par_typ    = pt;
    stop2      = s2;
    prescale   = pre;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1; p_data = '0; data_valid = 1'b0; par_en = 1'b0;
    par_typ = 1'b0; stop2 = 1'b0; prescale = '0;
    p_data5 = '0; data_valid5 = 1'b0;
    repeat (3) tick();
    chk("rst_tx", {7'b0, tx_out}, 8'd1);
    chk("rst_busy", {7'b0, busy}, 8'd0);
    chk("rst_ready", {7'b0, ready}, 8'd1);
    chk("rst_state", {5'b0, dbg_state}, 8'd0);
    rst = 1'b0;
    tick();
    chk("idle_ready", {7'b0, ready}, 8'd1);

    // T1: 0xAB, even parity, one stop bit, one clock per bit.
    push_bits(16'b01101010111, 11, 1, 1'b1);
    push_idle(2);
    send(8'hAB, 1'b1, 1'b0, 1'b0, 8'd0);
    run_check("t1", 1'b0, 13);

    // T2: back-to-back, 0x4C odd parity offered on the last stop clock.
    push_bits(16'b01101010111, 11, 1, 1'b1);
    push_bits(16'b00011001001, 11, 1, 1'b1);
    push_idle(2);
    send(8'hAB, 1'b1, 1'b0, 1'b0, 8'd0);
    run_check("t2a", 1'b0, 5);
    chk("t2_mid_ready", {7'b0, ready}, 8'd0);
    run_check("t2b", 1'b0, 5);
    chk("t2_last_ready", {7'b0, ready}, 8'd1);
    p_data = 8'h4C; par_typ = 1'b1; data_valid = 1'b1;
    run_check("t2c", 1'b0, 1);
    data_valid = 1'b0;
    run_check("t2d", 1'b0, 13);

    // T3: prescale 3, no parity, two stop bits; inputs disturbed mid-frame.
    push_bits(16'b01111000011, 11, 4, 1'b1);
    push_idle(2);
    send(8'h0F, 1'b0, 1'b0, 1'b1, 8'd3);
    prescale = 8'd0; stop2 = 1'b0; par_en = 1'b1; p_data = 8'hFF;
    run_check("t3", 1'b0, 46);

    // T4: 0xF0 offered mid-frame.
    push_bits(16'b01101010111, 11, 1, 1'b1);
`ifdef UART_TX_HOLD_EN
    push_bits(16'b00000111101, 11, 1, 1'b1);
`endif
    push_idle(2);
    send(8'hAB, 1'b1, 1'b0, 1'b0, 8'd0);
    run_check("t4a", 1'b0, 4);
    p_data = 8'hF0; data_valid = 1'b1;
`ifdef UART_TX_HOLD_EN
    chk("t4_ready_in", {7'b0, ready}, 8'd1);
`else
    chk("t4_ready_in", {7'b0, ready}, 8'd0);
`endif
    run_check("t4b", 1'b0, 1);
    data_valid = 1'b0;
    chk("t4_ready_after", {7'b0, ready}, 8'd0);
`ifdef UART_TX_HOLD_EN
    run_check("t4c", 1'b0, 19);
`else
    run_check("t4c", 1'b0, 8);
`endif

    // T5: 5-bit instance, odd parity, 5'b10011.
    push_bits(16'b01100101, 8, 1, 1'b1);
    push_idle(2);
    p_data5 = 5'b10011; par_en = 1'b1; par_typ = 1'b1; stop2 = 1'b0;
    prescale = 8'd0; data_valid5 = 1'b1;
    tick();
    data_valid5 = 1'b0;
    run_check("t5", 1'b1, 10);

    // T6: reset during data bit 3, then reset together with DATA_VALID.
    push_bits(16'b01101, 5, 1, 1'b1);
    send(8'hAB, 1'b1, 1'b0, 1'b0, 8'd0);
    run_check("t6a", 1'b0, 4);
    rst = 1'b1;
    run_check("t6b", 1'b0, 1);
    rst = 1'b0;
    chk("t6_abort_tx", {7'b0, tx_out}, 8'd1);
    chk("t6_abort_busy", {7'b0, busy}, 8'd0);
    chk("t6_abort_ready", {7'b0, ready}, 8'd1);
    chk("t6_abort_state", {5'b0, dbg_state}, 8'd0);

    rst = 1'b1; p_data = 8'h4C; par_typ = 1'b1; data_valid = 1'b1;
    tick();
    rst = 1'b0; data_valid = 1'b0;
    chk("t6_rstwin_tx", {7'b0, tx_out}, 8'd1);
    chk("t6_rstwin_busy", {7'b0, busy}, 8'd0);
    tick();
    chk("t6_rstwin_busy2", {7'b0, busy}, 8'd0);

    push_bits(16'b00011001001, 11, 1, 1'b1);
    push_idle(2);
    send(8'h4C, 1'b1, 1'b1, 1'b0, 8'd0);
    run_check("t6c", 1'b0, 13);

    // ---------------- final report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Run-time bound.
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
